// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and LS, one transaction at a time.
// MEMARB_RR_EN selects round-robin arbitration instead of LS priority with an IF starvation limit.
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic [DW-1:0]   if_rdata,
   output logic            if_ack,
   input  logic            ls_req,
   input  logic            ls_we,
   input  logic [DW/8-1:0] ls_be,
   input  logic [AW-1:0]   ls_addr,
   input  logic [DW-1:0]   ls_wdata,
   output logic [DW-1:0]   ls_rdata,
   output logic            ls_ack,
   output logic            mem_req,
   output logic            mem_we,
   output logic [DW/8-1:0] mem_be,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   input  logic            mem_ready,
   output logic            mem_sel,
   output logic            busy
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state;
   logic   gnt;
   logic   pick;
`ifdef MEMARB_RR_EN
   logic last_gnt;
   assign pick = (if_req && ls_req) ? ~last_gnt : ls_req;
`else
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
   logic [CW-1:0] starve_cnt;
   assign pick = (if_req && ls_req) ? (starve_cnt != LIM) : ls_req;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 1'b0;
`ifdef MEMARB_RR_EN
         last_gnt <= 1'b1;
`else
         starve_cnt <= '0;
`endif
      end else if (state == IDLE) begin
         if (if_req || ls_req) begin
            state <= BUSY;
            gnt   <= pick;
`ifdef MEMARB_RR_EN
            last_gnt <= pick;
`else
            starve_cnt <= (!pick || !if_req) ? '0 :
                          (starve_cnt == LIM) ? LIM : starve_cnt + 1'b1;
`endif
         end
      end else if (mem_ready) begin
         state <= IDLE;
      end
   end
   assign busy      = (state == BUSY);
   assign mem_req   = busy;
   assign mem_sel   = busy & gnt;
   assign mem_we    = mem_sel & ls_we;
   assign mem_be    = mem_sel ? ls_be : '1;
   assign mem_addr  = mem_sel ? ls_addr : if_addr;
   assign mem_wdata = mem_sel ? ls_wdata : '0;
   assign if_ack    = busy & mem_ready & ~gnt;
   assign ls_ack    = busy & mem_ready & gnt;
   assign if_rdata  = mem_rdata;
   assign ls_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;
   logic        clk = 0, rst_n = 0;
   logic        if_req = 0, ls_req = 0, ls_we = 0, mem_ready = 0;
   logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, mem_rdata = 0;
   logic [3:0]  ls_be = 0;
   logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
   logic        if_ack, ls_ack, mem_req, mem_we, mem_sel, busy;
   logic [3:0]  mem_be;
   int total = 0, bad = 0;

   typedef struct packed {
      logic        sel;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;
   txn_t q[$];

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ack(ls_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_sel(mem_sel), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push(input logic sel, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
      txn_t t;
      t.sel = sel; t.we = we; t.be = be; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
      q.push_back(t);
   endtask

   // Waits for the next transaction, checks it against the scoreboard head, completes it after lat cycles.
   task automatic serve(input int lat);
      txn_t e;
      int n = 0;
      while (!mem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("mem_req_timeout", {31'b0, mem_req}, 32'd1);
      if (q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = q.pop_front();
      chk("mem_sel", {31'b0, mem_sel}, {31'b0, e.sel});
      chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
      chk("mem_be", {28'b0, mem_be}, {28'b0, e.be});
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_wdata", mem_wdata, e.wdata);
      repeat (lat) begin
         @(negedge clk);
         chk("early_ack", {30'b0, if_ack, ls_ack}, 32'd0);
         chk("busy_hold", {31'b0, busy}, 32'd1);
      end
      mem_rdata = e.rdata;
      mem_ready = 1;
      #1;
      chk("acks", {30'b0, if_ack, ls_ack}, e.sel ? 32'd1 : 32'd2);
      chk("rdata", e.sel ? ls_rdata : if_rdata, e.rdata);
      @(posedge clk);
      #1;
      mem_ready = 0;
      chk("turnaround", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      // reset state
      #2;
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_acks", {30'b0, if_ack, ls_ack}, 32'd0);
      chk("rst_sel", {31'b0, mem_sel}, 32'd0);
      @(posedge clk); #1 rst_n = 1;

      // stray mem_ready in IDLE
      mem_ready = 1;
      repeat (2) begin
         @(negedge clk);
         chk("stray_acks", {30'b0, if_ack, ls_ack}, 32'd0);
         chk("stray_req", {31'b0, mem_req}, 32'd0);
      end
      @(posedge clk); #1 mem_ready = 0;

      // IF only
      if_req = 1; if_addr = 32'h100;
      push(0, 0, 4'hF, 32'h100, 0, 32'hDEADBEEF);
      @(negedge clk);
      chk("req_latency", {31'b0, mem_req}, 32'd0);
      serve(2);
      if_req = 0;

      // contention: LS first, then IF
      if_req = 1; if_addr = 32'h200;
      ls_req = 1; ls_we = 1; ls_addr = 32'h40; ls_wdata = 32'h12345678; ls_be = 4'h3;
      push(1, 1, 4'h3, 32'h40, 32'h12345678, 32'h0);
      push(0, 0, 4'hF, 32'h200, 0, 32'hCAFE0001);
      serve(1);
      ls_req = 0;
      serve(0);
      if_req = 0;

      // LS load dropping its request mid-transaction
      ls_req = 1; ls_we = 0; ls_addr = 32'h80; ls_be = 4'hF;
      push(1, 0, 4'hF, 32'h80, 32'h12345678, 32'hA5A5A5A5);
      @(posedge clk); @(posedge clk); #1 ls_req = 0;
      chk("drop_busy", {31'b0, busy}, 32'd1);
      serve(2);

      // both requesters held
      if_req = 1; if_addr = 32'h300;
      ls_req = 1; ls_we = 1; ls_addr = 32'h44; ls_wdata = 32'h0BADF00D; ls_be = 4'h1;
`ifdef MEMARB_RR_EN
      for (int i = 0; i < 4; i++)
         if (i % 2 == 0) push(0, 0, 4'hF, 32'h300, 0, 32'h1000 + i);
         else            push(1, 1, 4'h1, 32'h44, 32'h0BADF00D, 32'h1000 + i);
      for (int i = 0; i < 4; i++) serve(0);
`else
      for (int i = 0; i < 4; i++) push(1, 1, 4'h1, 32'h44, 32'h0BADF00D, 32'h2000 + i);
      push(0, 0, 4'hF, 32'h300, 0, 32'h2004);
      for (int i = 0; i < 5; i++) serve(0);
`endif
      if_req = 0; ls_req = 0;
      @(posedge clk); @(posedge clk); #1;
      if (busy) begin
         mem_ready = 1;
         @(posedge clk); #1 mem_ready = 0;
      end

      // reset mid-BUSY
      if_req = 1; if_addr = 32'h500;
      n = 0;
      while (!mem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_busy_reached", {31'b0, mem_req}, 32'd1);
      @(negedge clk);
      rst_n = 0; mem_ready = 1;
      #1;
      chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_acks", {30'b0, if_ack, ls_ack}, 32'd0);
      @(posedge clk); #1 mem_ready = 0; rst_n = 1;
      push(0, 0, 4'hF, 32'h500, 0, 32'h55AA55AA);
      serve(1);
      if_req = 0;
      chk("scoreboard_drained", q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
